cart_loader: RTL and testbench

CART_LOADER -- requirements
Module: cart_loader

---
 rtl/cart_loader.sv | 187 ++++++++++++++++++
 tb/tb_cart_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_loader.sv
// ---------------------------------------------------------------------------
// cart_loader
//
// Loads a cartridge image from the HPS download channel into a 16 KiB
// cartridge RAM, holds the CPU in reset while the image is loaded and for a
// settling period afterwards, then serves CPU reads from the cartridge
// window with power-of-two mirroring.
//
// Ports
//   clk             system clock, all registers on its rising edge
//   reset           asynchronous active-low reset
//   ioctl_download  HPS download in progress
//   ioctl_index     download image selector (ROM_INDEX selects a cartridge)
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address within the image
//   ioctl_data      byte value
//   cpu_addr        CPU offset inside the cartridge window
//   cpu_rd          one-cycle CPU read request
//   cpu_dout        read data, valid while cpu_ack is high
//   cpu_ack         read-data-valid pulse, two cycles after cpu_rd
//   mem_addr        cartridge RAM address
//   mem_din         cartridge RAM write data
//   mem_we          cartridge RAM write enable
//   mem_dout        cartridge RAM read data (registered, 1-cycle latency)
//   cpu_reset_n     low holds the machine in reset
//   cart_present    a non-empty image is loaded
//   cart_irq        CART line to PIA CB1 for autostart
//   overflow        the last image was larger than 16 KiB
// ---------------------------------------------------------------------------
module cart_loader #(
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter logic [7:0]  ROM_INDEX   = 8'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic [13:0] cpu_addr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic [13:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout,
  output logic        cpu_reset_n,
  output logic        cart_present,
  output logic        cart_irq,
  output logic        overflow
);

  localparam int unsigned     HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_INIT = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t            state;
  logic [14:0]       len;
  logic [13:0]       mask;
  logic [HC_W-1:0]   hold_cnt;
  logic [13:0]       wr_addr_p0;
  logic              rd_vld_p0;
  logic              rd_hit_p0;

  // Image length after a byte at address a: a+1, saturating at 15 bits.
  function automatic logic [14:0] sat_len(input logic [15:0] a);
    logic [16:0] s;
    s = {1'b0, a} + 17'd1;
    return (s > 17'd32767) ? 15'h7FFF : s[14:0];
  endfunction

  // Smallest power of two >= l, minus one, clamped to [2047, 16383].
  function automatic logic [13:0] mirror_mask(input logic [14:0] l);
    logic [14:0] m;
    if (l <= 15'd2048) return 14'h07FF;
    if (l > 15'd16384) return 14'h3FFF;
    m = l - 15'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    return m[13:0];
  endfunction

  // A qualifying download restarts the sequence from any state but LOAD;
  // the write strobe in the same cycle as the restart is still taken.
  logic        start;
  logic        dl_active;
  logic        wr_ok;
  logic        in_range;
  logic [14:0] wr_len;

  assign start     = ioctl_download && (ioctl_index == ROM_INDEX) && (state != LOAD);
  assign dl_active = start || ((state == LOAD) && ioctl_download);
  assign wr_ok     = dl_active && ioctl_wr;
  assign in_range  = (ioctl_addr[15:14] == 2'b00);
  assign wr_len    = sat_len(ioctl_addr);

  // The download path owns the RAM address whenever a write can be pending;
  // otherwise the CPU address goes straight to the RAM so the registered
  // RAM output lines up with the two-cycle acknowledge.
  assign mem_addr = (state == LOAD) ? wr_addr_p0 :
                    (cpu_rd ? (cpu_addr & mask) : 14'd0);

  // ---- stage p0: download write register and sequencing FSM ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      len          <= '0;
      mask         <= 14'h3FFF;
      hold_cnt     <= '0;
      wr_addr_p0   <= '0;
      mem_din      <= '0;
      mem_we       <= 1'b0;
      cpu_reset_n  <= 1'b1;
      cart_present <= 1'b0;
      cart_irq     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (wr_ok) begin
        wr_addr_p0 <= ioctl_addr[13:0];
        mem_din    <= ioctl_data;
        mem_we     <= in_range;
      end

      if (start) begin
        state        <= LOAD;
        cpu_reset_n  <= 1'b0;
        cart_present <= 1'b0;
        cart_irq     <= 1'b0;
        overflow     <= wr_ok && !in_range;
        len          <= wr_ok ? wr_len : 15'd0;
      end else begin
        case (state)
          LOAD: begin
            if (ioctl_download) begin
              if (wr_ok) begin
                if (!in_range) overflow <= 1'b1;
                if (wr_len > len) len <= wr_len;
              end
            end else begin
              state    <= HOLD;
              hold_cnt <= HOLD_INIT;
            end
          end
          HOLD: begin
            if (hold_cnt == '0) begin
              state        <= RUN;
              cpu_reset_n  <= 1'b1;
              cart_present <= (len != 15'd0);
              cart_irq     <= (len != 15'd0);
              mask         <= mirror_mask(len);
            end else begin
              hold_cnt <= hold_cnt - HC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---- stage p0 -> p1: CPU read pipeline, RAM latency then acknowledge ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_p0 <= 1'b0;
      rd_hit_p0 <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_dout  <= 8'hFF;
    end else if (start) begin
      // A new download drops every read still in flight.
      rd_vld_p0 <= 1'b0;
      rd_hit_p0 <= 1'b0;
      cpu_ack   <= 1'b0;
    end else begin
      rd_vld_p0 <= cpu_rd;
      rd_hit_p0 <= cpu_rd && (state == RUN) && cart_present;
      cpu_ack   <= rd_vld_p0;
      if (rd_vld_p0) cpu_dout <= rd_hit_p0 ? mem_dout : 8'hFF;
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
module tb_cart_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [13:0] cpu_addr;
  logic        cpu_rd;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic [13:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic        cpu_reset_n;
  logic        cart_present;
  logic        cart_irq;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int we_cnt = 0;

  logic [7:0] ram [16384];

  cart_loader dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .cpu_reset_n(cpu_reset_n), .cart_present(cart_present),
    .cart_irq(cart_irq), .overflow(overflow)
  );

  always #10 clk = ~clk;

  // Cartridge RAM model: synchronous write, registered read.
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      ram[mem_addr] <= mem_din;
      we_cnt++;
    end
    mem_dout <= ram[mem_addr];
  end

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'(a >> 8);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dl_byte(input int a);
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 16'(a);
    ioctl_data     = pat(a);
    tick();
    ioctl_wr       = 1'b0;
  endtask

  task automatic dl_run(input int base, input int n);
    for (int i = 0; i < n; i++) dl_byte(base + i);
  endtask

  task automatic dl_end();
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    tick();
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (cpu_reset_n !== 1'b1 && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic do_read(input logic [13:0] a, output logic [7:0] d, output int lat);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    lat      = 0;
    d        = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      cpu_rd = 1'b0;
      if (cpu_ack === 1'b1) begin
        lat = k;
        d   = cpu_dout;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++; if (cpu_reset_n !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset_n: got %b want 1", cpu_reset_n); end
    checks++; if (cart_present !== 1'b0) begin errors++; $display("FAIL rst_cart_present: got %b want 0", cart_present); end
    checks++; if (cart_irq !== 1'b0) begin errors++; $display("FAIL rst_cart_irq: got %b want 0", cart_irq); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_cpu_ack: got %b want 0", cpu_ack); end
    checks++; if (cpu_dout !== 8'hFF) begin errors++; $display("FAIL rst_cpu_dout: got %h want ff", cpu_dout); end
    checks++; if (mem_addr !== 14'd0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_din !== 8'd0) begin errors++; $display("FAIL rst_mem_din: got %h want 0", mem_din); end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (cpu_reset_n !== 1'b1) begin errors++; $display("FAIL idle_after_reset: cpu_reset_n got %b want 1", cpu_reset_n); end
  endtask

  task automatic test_ignore_index();
    logic [7:0] d;
    int lat;
    int low = 0;
    we_cnt = 0;
    ioctl_index = 8'd2;
    for (int i = 0; i < 50; i++) begin
      dl_byte(i);
      if (cpu_reset_n !== 1'b1) low++;
    end
    dl_end();
    if (cpu_reset_n !== 1'b1) low++;
    checks++; if (we_cnt !== 0) begin errors++; $display("FAIL idx2_writes: got %0d want 0", we_cnt); end
    checks++; if (low !== 0) begin errors++; $display("FAIL idx2_cpu_reset_low: got %0d cycles want 0", low); end
    do_read(14'h0005, d, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL idle_read_latency: got %0d want 2", lat); end
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL idle_read_data: got %h want ff", d); end
  endtask

  task automatic test_download_8k();
    logic [7:0] d;
    int lat;
    int n;
    we_cnt = 0;
    ioctl_index = 8'd1;
    dl_run(0, 8192);
    dl_end();
    checks++; if (we_cnt !== 8192) begin errors++; $display("FAIL dl8k_writes: got %0d want 8192", we_cnt); end
    wait_run(n);
    checks++; if (n !== 1024) begin errors++; $display("FAIL dl8k_hold_cycles: got %0d want 1024", n); end
    checks++; if (cart_present !== 1'b1) begin errors++; $display("FAIL dl8k_present: got %b want 1", cart_present); end
    checks++; if (cart_irq !== 1'b1) begin errors++; $display("FAIL dl8k_irq: got %b want 1", cart_irq); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dl8k_overflow: got %b want 0", overflow); end
    do_read(14'h2005, d, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL dl8k_read_latency: got %0d want 2", lat); end
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL dl8k_read_2005: got %h want 05", d); end
    do_read(14'h0805, d, lat);
    checks++; if (d !== 8'h0D) begin errors++; $display("FAIL dl8k_read_0805: got %h want 0d", d); end
    do_read(14'h3FFF, d, lat);
    checks++; if (d !== 8'hE0) begin errors++; $display("FAIL dl8k_read_3fff: got %h want e0", d); end
  endtask

  task automatic test_back_to_back();
    cpu_rd = 1'b1; cpu_addr = 14'h0001; tick();
    cpu_addr = 14'h0002; tick();
    cpu_addr = 14'h0003;
    checks++; if (cpu_ack !== 1'b1 || cpu_dout !== 8'h01) begin errors++; $display("FAIL b2b_first: ack=%b data=%h want ack=1 data=01", cpu_ack, cpu_dout); end
    tick();
    cpu_rd = 1'b0;
    checks++; if (cpu_ack !== 1'b1 || cpu_dout !== 8'h02) begin errors++; $display("FAIL b2b_second: ack=%b data=%h want ack=1 data=02", cpu_ack, cpu_dout); end
    tick();
    checks++; if (cpu_ack !== 1'b1 || cpu_dout !== 8'h03) begin errors++; $display("FAIL b2b_third: ack=%b data=%h want ack=1 data=03", cpu_ack, cpu_dout); end
    tick();
    checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL b2b_no_extra_ack: got %b want 0", cpu_ack); end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    int lat;
    int n;
    we_cnt = 0;
    ioctl_index = 8'd1;
    dl_run(0, 16385);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    dl_end();
    checks++; if (we_cnt !== 16384) begin errors++; $display("FAIL ovf_writes: got %0d want 16384", we_cnt); end
    checks++; if (ram[0] !== 8'h00) begin errors++; $display("FAIL ovf_byte0_intact: got %h want 00", ram[0]); end
    wait_run(n);
    checks++; if (n !== 1024) begin errors++; $display("FAIL ovf_hold_cycles: got %0d want 1024", n); end
    checks++; if (overflow !== 1'b1 || cart_present !== 1'b1) begin errors++; $display("FAIL ovf_run_flags: ovf=%b present=%b want 1 1", overflow, cart_present); end
    do_read(14'h3005, d, lat);
    checks++; if (d !== 8'h35) begin errors++; $display("FAIL ovf_mask_read_3005: got %h want 35", d); end
  endtask

  task automatic test_restart_in_hold();
    logic [7:0] d;
    int lat;
    int n;
    int high = 0;
    ioctl_index = 8'd1;
    dl_byte(12000);
    dl_byte(20000);
    dl_end();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL restart_first_ovf: got %b want 1", overflow); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_reset_n !== 1'b0) high++;
    end
    do_read(14'h0005, d, lat);
    checks++; if (lat !== 2 || d !== 8'hFF) begin errors++; $display("FAIL hold_read: lat=%0d data=%h want 2 ff", lat, d); end
    dl_run(0, 100);
    if (cpu_reset_n !== 1'b0) high++;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL restart_ovf_cleared: got %b want 0", overflow); end
    dl_end();
    checks++; if (high !== 0) begin errors++; $display("FAIL restart_cpu_reset_high: got %0d cycles want 0", high); end
    wait_run(n);
    checks++; if (n !== 1024) begin errors++; $display("FAIL restart_hold_cycles: got %0d want 1024", n); end
    do_read(14'h0805, d, lat);
    checks++; if (d !== 8'h05) begin errors++; $display("FAIL restart_mask_read_0805: got %h want 05", d); end
  endtask

  task automatic test_cancel_zero_byte();
    logic [7:0] d;
    int lat;
    int n;
    int acks = 0;
    ioctl_index = 8'd1;
    cpu_addr = 14'h0005; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
    ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_ack !== 1'b0) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL cancel_acks: got %0d want 0", acks); end
    dl_end();
    wait_run(n);
    checks++; if (n !== 1024) begin errors++; $display("FAIL zero_hold_cycles: got %0d want 1024", n); end
    checks++; if (cart_present !== 1'b0 || cart_irq !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL zero_flags: present=%b irq=%b ovf=%b want 0 0 0", cart_present, cart_irq, overflow); end
    do_read(14'h0005, d, lat);
    checks++; if (lat !== 2 || d !== 8'hFF) begin errors++; $display("FAIL zero_read: lat=%0d data=%h want 2 ff", lat, d); end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] d;
    int lat;
    int low = 0;
    we_cnt = 0;
    ioctl_index = 8'd1;
    dl_run(0, 100);
    tick();
    checks++; if (we_cnt !== 100) begin errors++; $display("FAIL midrst_writes_before: got %0d want 100", we_cnt); end
    ioctl_wr = 1'b1; ioctl_addr = 16'd100; ioctl_data = pat(100);
    #3 reset = 1'b0;
    #1;
    checks++; if (cpu_reset_n !== 1'b1 || cart_present !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL midrst_async: cpu_reset_n=%b present=%b we=%b want 1 0 0", cpu_reset_n, cart_present, mem_we); end
    for (int i = 0; i < 5; i++) tick();
    ioctl_download = 1'b0; ioctl_wr = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_reset_n !== 1'b1) low++;
    end
    checks++; if (we_cnt !== 100) begin errors++; $display("FAIL midrst_no_more_writes: got %0d want 100", we_cnt); end
    checks++; if (low !== 0) begin errors++; $display("FAIL midrst_stays_idle: got %0d low cycles want 0", low); end
    do_read(14'h0005, d, lat);
    checks++; if (lat !== 2 || d !== 8'hFF) begin errors++; $display("FAIL midrst_idle_read: lat=%0d data=%h want 2 ff", lat, d); end
  endtask

  initial begin
    reset = 1'b0;
    ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = 16'd0; ioctl_data = 8'd0;
    cpu_addr = 14'd0; cpu_rd = 1'b0;
    test_reset();
    test_ignore_index();
    test_download_8k();
    test_back_to_back();
    test_overflow();
    test_restart_in_hold();
    test_cancel_zero_byte();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
